// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end: FSM encodings, reset PC and PC step.
package mips_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0100_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, insn} holding buffer that absorbs an imem word ID cannot take yet.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_insn,
    output logic            full,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] insn
);

    // Clear wins so a redirect always cancels a word that arrives alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 1'b0;
            pc   <= '0;
            insn <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            pc   <= load_pc;
            insn <= load_insn;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: sequences single-outstanding imem reads, handles redirects with a
// delay slot and presents instructions to ID through a registered if_* stage plus a skid.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            w_stall,
    input  logic            w_redirect,
    input  logic [XLEN-1:0] w_redirect_pc_32,
    output logic            w_imem_req,
    output logic [XLEN-1:0] w_imem_addr_32,
    input  logic            w_imem_ack,
    input  logic [XLEN-1:0] w_imem_data_32,
    output logic            w_if_valid,
    output logic [XLEN-1:0] w_if_pc_32,
    output logic [XLEN-1:0] w_if_insn_32,
    output logic [XLEN-1:0] w_pc_32,
    output fetch_state_t    w_fetch_state
);

    // Handshakes: imem req/addr are held until the ack cycle and the ack is never
    // refused; ID takes if_* on any edge with w_if_valid=1 and w_stall=0.

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            consume;
    logic            slot_free;
    logic            ack_take;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_seq;
    logic            skid_full;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_insn;
    logic            skid_load;
    logic            skid_pop;

    assign consume   = w_if_valid & ~w_stall;
    assign slot_free = ~w_if_valid | consume;
    assign ack_take  = (state == FETCH_REQ) & w_imem_ack;
    assign target    = align_pc(w_redirect_pc_32);
    assign pc_seq    = pc + PC_INC;
    assign skid_load = ack_take & ~w_redirect & ~slot_free;
    assign skid_pop  = slot_free & ~w_redirect;

    assign w_pc_32       = pc;
    assign w_fetch_state = state;

    fetch_skid_buf u_skid (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load),
        .pop       (skid_pop),
        .clear     (w_redirect),
        .load_pc   (w_imem_addr_32),
        .load_insn (w_imem_data_32),
        .full      (skid_full),
        .pc        (skid_pc),
        .insn      (skid_insn)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= FETCH_IDLE;
            pc             <= RESET_PC;
            w_imem_req     <= 1'b0;
            w_imem_addr_32 <= '0;
            w_if_valid     <= 1'b0;
            w_if_pc_32     <= '0;
            w_if_insn_32   <= '0;
        end else begin
            // The word on if_* at a redirect is the delay slot; anything younger is dropped.
            if (w_redirect) begin
                if (consume) begin
                    w_if_valid <= 1'b0;
                end
            end else if (slot_free) begin
                if (skid_full) begin
                    w_if_valid   <= 1'b1;
                    w_if_pc_32   <= skid_pc;
                    w_if_insn_32 <= skid_insn;
                end else if (ack_take) begin
                    w_if_valid   <= 1'b1;
                    w_if_pc_32   <= w_imem_addr_32;
                    w_if_insn_32 <= w_imem_data_32;
                end else begin
                    w_if_valid <= 1'b0;
                end
            end

            case (state)
                FETCH_IDLE: begin
                    if (w_redirect) begin
                        pc             <= target;
                        state          <= FETCH_REQ;
                        w_imem_req     <= 1'b1;
                        w_imem_addr_32 <= target;
                    end else if (!skid_full) begin
                        state          <= FETCH_REQ;
                        w_imem_req     <= 1'b1;
                        w_imem_addr_32 <= pc;
                    end
                end
                FETCH_REQ: begin
                    if (w_redirect) begin
                        pc <= target;
                        if (w_imem_ack) begin
                            w_imem_addr_32 <= target;
                        end else begin
                            state <= FETCH_DRAIN;
                        end
                    end else if (w_imem_ack) begin
                        pc <= pc_seq;
                        if (skid_load) begin
                            state      <= FETCH_IDLE;
                            w_imem_req <= 1'b0;
                        end else begin
                            w_imem_addr_32 <= pc_seq;
                        end
                    end
                end
                FETCH_DRAIN: begin
                    // A redirect coinciding with the discarded ack starts straight at its target.
                    if (w_imem_ack) begin
                        state          <= FETCH_REQ;
                        w_imem_addr_32 <= w_redirect ? target : pc;
                        if (w_redirect) begin
                            pc <= target;
                        end
                    end else if (w_redirect) begin
                        pc <= target;
                    end
                end
                default: begin
                    state      <= FETCH_IDLE;
                    w_imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: an imem responder, an instruction-stream model
// checked every cycle, and hand-computed expectations for each scenario.
module tb_fetch_sequencer;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0100_0000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         w_stall = 1'b0;
    logic         w_redirect = 1'b0;
    logic [31:0]  w_redirect_pc_32 = '0;
    logic         w_imem_req;
    logic [31:0]  w_imem_addr_32;
    logic         w_imem_ack = 1'b0;
    logic [31:0]  w_imem_data_32 = '0;
    logic         w_if_valid;
    logic [31:0]  w_if_pc_32;
    logic [31:0]  w_if_insn_32;
    logic [31:0]  w_pc_32;
    fetch_state_t w_fetch_state;

    int checks = 0;
    int errors = 0;

    int       wait_states = 0;
    bit       ack_block = 1'b0;
    int       wait_cnt = 0;
    logic [7:0] ack_tag = 8'h10;

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clock            (clock),
        .reset            (reset),
        .w_stall          (w_stall),
        .w_redirect       (w_redirect),
        .w_redirect_pc_32 (w_redirect_pc_32),
        .w_imem_req       (w_imem_req),
        .w_imem_addr_32   (w_imem_addr_32),
        .w_imem_ack       (w_imem_ack),
        .w_imem_data_32   (w_imem_data_32),
        .w_if_valid       (w_if_valid),
        .w_if_pc_32       (w_if_pc_32),
        .w_if_insn_32     (w_if_insn_32),
        .w_pc_32          (w_pc_32),
        .w_fetch_state    (w_fetch_state)
    );

    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // imem responder: acks after wait_states idle request cycles; data tags each ack.
    always begin
        @(negedge clock);
        #1;
        if (w_imem_req && !ack_block && wait_cnt >= wait_states) begin
            w_imem_ack     = 1'b1;
            w_imem_data_32 = {ack_tag, w_imem_addr_32[23:0]};
            ack_tag        = ack_tag + 8'd1;
            wait_cnt       = 0;
        end else begin
            w_imem_ack     = 1'b0;
            w_imem_data_32 = 32'hBAD0_0000;
            wait_cnt       = w_imem_req ? wait_cnt + 1 : 0;
        end
    end

    // Stream model: exp_q holds words owed to ID in order, front = word on if_*.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = RST_PC;
    bit          m_cancel = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always begin
        @(negedge clock);
        #2;
        if (reset) begin
            exp_q.delete();
            m_pc      = RST_PC;
            m_cancel  = 1'b0;
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
            prev_addr = '0;
        end else begin
            logic [63:0] keep;
            bit          consume;
            check32("m_if_valid", {31'd0, w_if_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                keep = exp_q[0];
                check32("m_if_pc", w_if_pc_32, keep[63:32]);
                check32("m_if_insn", w_if_insn_32, keep[31:0]);
            end
            check32("m_pc", w_pc_32, m_pc);
            if (prev_req && !prev_ack) begin
                check32("m_req_hold", {31'd0, w_imem_req}, 32'd1);
                check32("m_addr_hold", w_imem_addr_32, prev_addr);
            end else if (w_imem_req) begin
                check32("m_new_addr", w_imem_addr_32, m_pc);
            end
            if (exp_q.size() >= 2) begin
                check32("m_req_skid_full", {31'd0, w_imem_req}, 32'd0);
            end

            consume = (exp_q.size() != 0) && !w_stall;
            if (w_redirect) begin
                if (exp_q.size() != 0 && !consume) begin
                    keep = exp_q[0];
                    exp_q.delete();
                    exp_q.push_back(keep);
                end else begin
                    exp_q.delete();
                end
                m_pc = w_redirect_pc_32 & 32'hFFFF_FFFC;
                if (w_imem_req && !w_imem_ack) m_cancel = 1'b1;
                else if (w_imem_ack) m_cancel = 1'b0;
            end else begin
                if (consume) void'(exp_q.pop_front());
                if (w_imem_ack) begin
                    if (!m_cancel) begin
                        exp_q.push_back({w_imem_addr_32, w_imem_data_32});
                        m_pc = m_pc + 32'd4;
                    end
                    m_cancel = 1'b0;
                end
            end
            prev_req  = w_imem_req;
            prev_ack  = w_imem_ack;
            prev_addr = w_imem_addr_32;
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset(input bit check_it);
        reset       = 1'b1;
        w_stall     = 1'b0;
        w_redirect  = 1'b0;
        ack_block   = 1'b0;
        wait_states = 0;
        step();
        step();
        if (check_it) begin
            check32("rst_req", {31'd0, w_imem_req}, 32'd0);
            check32("rst_addr", w_imem_addr_32, 32'd0);
            check32("rst_if_valid", {31'd0, w_if_valid}, 32'd0);
            check32("rst_if_pc", w_if_pc_32, 32'd0);
            check32("rst_if_insn", w_if_insn_32, 32'd0);
            check32("rst_pc", w_pc_32, RST_PC);
            check32("rst_state", {30'd0, w_fetch_state}, {30'd0, FETCH_IDLE});
        end
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] stall_vec;

        // 1: ack every cycle, one instruction per cycle
        do_reset(1'b1);
        check32("t1_req_c0", {31'd0, w_imem_req}, 32'd0);
        step();
        check32("t1_req_c1", {31'd0, w_imem_req}, 32'd1);
        check32("t1_addr_c1", w_imem_addr_32, 32'h0100_0000);
        check32("t1_valid_c1", {31'd0, w_if_valid}, 32'd0);
        step();
        check32("t1_valid_c2", {31'd0, w_if_valid}, 32'd1);
        check32("t1_ifpc_c2", w_if_pc_32, 32'h0100_0000);
        check32("t1_addr_c2", w_imem_addr_32, 32'h0100_0004);
        step();
        check32("t1_ifpc_c3", w_if_pc_32, 32'h0100_0004);
        check32("t1_addr_c3", w_imem_addr_32, 32'h0100_0008);
        step();
        check32("t1_ifpc_c4", w_if_pc_32, 32'h0100_0008);

        // 2: two wait states
        do_reset(1'b0);
        wait_states = 2;
        step();
        check32("t2_addr_c1", w_imem_addr_32, 32'h0100_0000);
        step();
        check32("t2_addr_c2", w_imem_addr_32, 32'h0100_0000);
        check32("t2_valid_c2", {31'd0, w_if_valid}, 32'd0);
        step();
        check32("t2_addr_c3", w_imem_addr_32, 32'h0100_0000);
        check32("t2_valid_c3", {31'd0, w_if_valid}, 32'd0);
        step();
        check32("t2_valid_c4", {31'd0, w_if_valid}, 32'd1);
        check32("t2_ifpc_c4", w_if_pc_32, 32'h0100_0000);
        check32("t2_addr_c4", w_imem_addr_32, 32'h0100_0004);

        // 3: stall for three cycles fills the skid
        do_reset(1'b0);
        step();
        step();
        check32("t3_ifpc_c2", w_if_pc_32, 32'h0100_0000);
        w_stall = 1'b1;
        step();
        check32("t3_ifpc_c3", w_if_pc_32, 32'h0100_0000);
        check32("t3_req_c3", {31'd0, w_imem_req}, 32'd0);
        check32("t3_state_c3", {30'd0, w_fetch_state}, {30'd0, FETCH_IDLE});
        step();
        check32("t3_ifpc_c4", w_if_pc_32, 32'h0100_0000);
        check32("t3_req_c4", {31'd0, w_imem_req}, 32'd0);
        step();
        check32("t3_ifpc_c5", w_if_pc_32, 32'h0100_0000);
        w_stall = 1'b0;
        step();
        check32("t3_ifpc_c6", w_if_pc_32, 32'h0100_0004);
        check32("t3_valid_c6", {31'd0, w_if_valid}, 32'd1);
        check32("t3_req_c6", {31'd0, w_imem_req}, 32'd0);
        step();
        check32("t3_req_c7", {31'd0, w_imem_req}, 32'd1);
        check32("t3_addr_c7", w_imem_addr_32, 32'h0100_0008);

        // 4: redirect with ack pending, delay slot held by a stall
        do_reset(1'b0);
        repeat (4) step();
        check32("t4_ifpc_c4", w_if_pc_32, 32'h0100_0008);
        check32("t4_addr_c4", w_imem_addr_32, 32'h0100_000C);
        w_redirect       = 1'b1;
        w_redirect_pc_32 = 32'h0000_2000;
        w_stall          = 1'b1;
        ack_block        = 1'b1;
        step();
        w_redirect = 1'b0;
        ack_block  = 1'b0;
        check32("t4_ifpc_c5", w_if_pc_32, 32'h0100_0008);
        check32("t4_valid_c5", {31'd0, w_if_valid}, 32'd1);
        check32("t4_addr_c5", w_imem_addr_32, 32'h0100_000C);
        check32("t4_pc_c5", w_pc_32, 32'h0000_2000);
        check32("t4_state_c5", {30'd0, w_fetch_state}, {30'd0, FETCH_DRAIN});
        step();
        w_stall = 1'b0;
        check32("t4_addr_c6", w_imem_addr_32, 32'h0000_2000);
        check32("t4_ifpc_c6", w_if_pc_32, 32'h0100_0008);
        step();
        check32("t4_ifpc_c7", w_if_pc_32, 32'h0000_2000);
        check32("t4_valid_c7", {31'd0, w_if_valid}, 32'd1);

        // 5: redirect coinciding with an ack
        do_reset(1'b0);
        step();
        step();
        check32("t5_addr_c2", w_imem_addr_32, 32'h0100_0004);
        w_redirect       = 1'b1;
        w_redirect_pc_32 = 32'h0000_3000;
        step();
        w_redirect = 1'b0;
        check32("t5_valid_c3", {31'd0, w_if_valid}, 32'd0);
        check32("t5_addr_c3", w_imem_addr_32, 32'h0000_3000);
        check32("t5_pc_c3", w_pc_32, 32'h0000_3000);
        step();
        check32("t5_ifpc_c4", w_if_pc_32, 32'h0000_3000);

        // 6: wrap, unaligned target, reset during DRAIN
        do_reset(1'b0);
        step();
        w_redirect       = 1'b1;
        w_redirect_pc_32 = 32'hFFFF_FFFC;
        step();
        w_redirect = 1'b0;
        check32("t6_addr_top", w_imem_addr_32, 32'hFFFF_FFFC);
        check32("t6_valid_c2", {31'd0, w_if_valid}, 32'd0);
        step();
        check32("t6_ifpc_top", w_if_pc_32, 32'hFFFF_FFFC);
        check32("t6_addr_wrap", w_imem_addr_32, 32'h0000_0000);
        check32("t6_pc_wrap", w_pc_32, 32'h0000_0000);
        w_redirect       = 1'b1;
        w_redirect_pc_32 = 32'h0000_2003;
        step();
        check32("t6_addr_align", w_imem_addr_32, 32'h0000_2000);
        check32("t6_pc_align", w_pc_32, 32'h0000_2000);
        w_redirect_pc_32 = 32'h0000_5000;
        ack_block        = 1'b1;
        step();
        w_redirect = 1'b0;
        check32("t6_state_drain", {30'd0, w_fetch_state}, {30'd0, FETCH_DRAIN});
        check32("t6_addr_drain", w_imem_addr_32, 32'h0000_2000);
        check32("t6_pc_drain", w_pc_32, 32'h0000_5000);
        reset = 1'b1;
        step();
        check32("t6_req_rst", {31'd0, w_imem_req}, 32'd0);
        check32("t6_pc_rst", w_pc_32, RST_PC);
        check32("t6_state_rst", {30'd0, w_fetch_state}, {30'd0, FETCH_IDLE});
        reset     = 1'b0;
        ack_block = 1'b0;
        step();
        check32("t6_req_restart", {31'd0, w_imem_req}, 32'd1);
        check32("t6_addr_restart", w_imem_addr_32, RST_PC);

        // 7: stall patterns with a redirect in the middle, model-checked only
        for (int cfg = 0; cfg < 2; cfg++) begin
            do_reset(1'b0);
            wait_states = cfg;
            stall_vec   = (cfg == 0) ? 32'b0110_0011_1000_1101_0111_0000_1100_1010
                                     : 32'b1001_1100_0110_0000_1110_0101_0011_0001;
            for (int i = 0; i < 32; i++) begin
                step();
                w_stall          = stall_vec[i];
                w_redirect       = (i == 17);
                w_redirect_pc_32 = 32'h0000_4000 + 32'(cfg);
            end
            step();
            w_stall    = 1'b0;
            w_redirect = 1'b0;
            repeat (6) step();
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
